// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering the control unit's level-held load/store
// strobes: one access per strobe rise, fixed read latency, registered responses.
module data_mem_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_BITS    = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  busy,
  output logic                  err
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_mem_read_q;
  logic                  r_mem_write_q;
  logic [ADDR_BITS-1:0]  r_word_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_busy;
  logic                  r_err;

  logic                  w_rd_rise;
  logic                  w_wr_rise;
  logic                  w_bad_addr;
  logic                  w_err_d;
  logic                  w_load_wr;
  logic                  w_load_rd;
  logic                  w_do_read;

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_BITS)-1];

  assign w_rd_rise  = mem_read  & ~r_mem_read_q;
  assign w_wr_rise  = mem_write & ~r_mem_write_q;
  assign w_bad_addr = (|addr[1:0]) | (|addr[31:ADDR_BITS+2]);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_err_d      = 1'b0;
    w_load_wr    = 1'b0;
    w_load_rd    = 1'b0;
    w_do_read    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_wr_rise || w_rd_rise) begin
          if (w_bad_addr) begin
            w_err_d = 1'b1;
          end else if (w_wr_rise) begin
            // A read rising together with the write is dropped and flagged.
            w_load_wr    = 1'b1;
            w_err_d      = w_rd_rise;
            w_next_state = S_WR;
          end else begin
            w_load_rd    = 1'b1;
            w_next_state = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        w_err_d = w_wr_rise | w_rd_rise;
        if (r_cnt == '0) begin
          w_do_read    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_WR: begin
        w_err_d      = w_wr_rise | w_rd_rise;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_mem_read_q  <= 1'b0;
      r_mem_write_q <= 1'b0;
      r_word_addr   <= '0;
      r_wdata       <= '0;
      r_cnt         <= '0;
      r_rdata       <= '0;
      r_rvalid      <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_mem_read_q  <= mem_read;
      r_mem_write_q <= mem_write;
      r_busy        <= (w_next_state != S_IDLE);
      r_err         <= w_err_d;
      r_rvalid      <= w_do_read;
      if (w_load_wr || w_load_rd) begin
        r_word_addr <= addr[ADDR_BITS+1:2];
      end
      if (w_load_wr) begin
        r_wdata <= wdata;
      end
      if (w_load_rd) begin
        r_cnt <= CNT_W'(READ_LATENCY - 1);
      end else if (r_state == S_RD_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_do_read) begin
        r_rdata <= r_mem[r_word_addr];
      end
    end
  end

  // NOTE: the array has no reset; contents survive rst_n and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (r_state == S_WR) begin
      r_mem[r_word_addr] <= r_wdata;
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign busy   = r_busy;
  assign err    = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: default-latency instance plus a
// READ_LATENCY=4 instance for the collision scenario.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        rvalid, busy, err;

  logic        mem_read4 = 1'b0, mem_write4 = 1'b0;
  logic [31:0] addr4 = '0, wdata4 = '0;
  logic [31:0] rdata4;
  logic        rvalid4, busy4, err4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .busy(busy), .err(err)
  );

  data_mem_responder #(.READ_LATENCY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read4), .mem_write(mem_write4),
    .addr(addr4), .wdata(wdata4), .rdata(rdata4), .rvalid(rvalid4), .busy(busy4), .err(err4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one strobe episode on the selected instance and records what came back.
  // lat counts edges from the edge that samples the rise to the edge raising rvalid.
  task automatic run_strobe(input bit sel, input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] wd, input int hold,
                            output int lat, output int nvalid, output int nerr,
                            output int nbusy, output logic [31:0] rd_out);
    lat = -1; nvalid = 0; nerr = 0; nbusy = 0;
    if (sel) begin mem_read4 = rd; mem_write4 = wr; addr4 = a; wdata4 = wd; end
    else     begin mem_read  = rd; mem_write  = wr; addr  = a; wdata  = wd; end
    for (int k = 1; k <= 12; k++) begin
      step();
      if (sel ? rvalid4 : rvalid) begin
        nvalid++;
        if (lat < 0) lat = k - 1;
      end
      if (sel ? err4 : err) nerr++;
      if (sel ? busy4 : busy) nbusy++;
      if (k == hold) begin
        if (sel) begin mem_read4 = 1'b0; mem_write4 = 1'b0; end
        else     begin mem_read  = 1'b0; mem_write  = 1'b0; end
      end else if (k < hold) begin
        if (sel) wdata4 = wd + k; else wdata = wd + k;
      end
    end
    rd_out = sel ? rdata4 : rdata;
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic expect_word(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    expect_word("reset_rdata", rdata, 32'h0);
    expect_int("reset_rvalid", int'(rvalid), 0);
    expect_int("reset_busy", int'(busy), 0);
    expect_int("reset_err", int'(err), 0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_store_load();
    int lat, nv, ne, nb;
    logic [31:0] d;
    run_strobe(0, 0, 1, 32'h10, 32'hDEADBEEF, 2, lat, nv, ne, nb, d);
    expect_int("store_busy_cycles", nb, 1);
    expect_int("store_err", ne, 0);
    expect_int("store_rvalid", nv, 0);
    run_strobe(0, 1, 0, 32'h10, 32'h0, 2, lat, nv, ne, nb, d);
    expect_int("load_latency", lat, 2);
    expect_int("load_rvalid_count", nv, 1);
    expect_int("load_busy_cycles", nb, 2);
    expect_word("load_rdata_held", d, 32'hDEADBEEF);
  endtask

  task automatic test_held_strobe();
    int lat, nv, ne, nb;
    logic [31:0] d;
    run_strobe(0, 0, 1, 32'h40, 32'h1000_0000, 6, lat, nv, ne, nb, d);
    expect_int("held_busy_cycles", nb, 1);
    expect_int("held_err", ne, 0);
    run_strobe(0, 1, 0, 32'h40, 32'h0, 2, lat, nv, ne, nb, d);
    expect_word("held_rise_wdata", d, 32'h1000_0000);
  endtask

  task automatic test_errors();
    int lat, nv, ne, nb;
    logic [31:0] d;
    run_strobe(0, 1, 0, 32'h13, 32'h0, 2, lat, nv, ne, nb, d);
    expect_int("misaligned_err", ne, 1);
    expect_int("misaligned_rvalid", nv, 0);
    expect_int("misaligned_busy", nb, 0);
    expect_word("misaligned_rdata_kept", d, 32'h1000_0000);
    run_strobe(0, 1, 0, 32'h1000, 32'h0, 2, lat, nv, ne, nb, d);
    expect_int("range_err", ne, 1);
    expect_int("range_rvalid", nv, 0);
    expect_word("range_rdata_kept", d, 32'h1000_0000);
  endtask

  task automatic test_top_word();
    int lat, nv, ne, nb;
    logic [31:0] d;
    run_strobe(0, 0, 1, 32'hFFC, 32'h0000_1234, 2, lat, nv, ne, nb, d);
    expect_int("top_word_store_err", ne, 0);
    run_strobe(0, 1, 0, 32'hFFC, 32'h0, 2, lat, nv, ne, nb, d);
    expect_word("top_word_rdata", d, 32'h0000_1234);
  endtask

  task automatic test_simultaneous();
    int lat, nv, ne, nb;
    logic [31:0] d;
    run_strobe(0, 1, 1, 32'h20, 32'h5, 2, lat, nv, ne, nb, d);
    expect_int("simul_err", ne, 1);
    expect_int("simul_rvalid", nv, 0);
    expect_int("simul_busy_cycles", nb, 1);
    run_strobe(0, 1, 0, 32'h20, 32'h0, 2, lat, nv, ne, nb, d);
    expect_word("simul_readback", d, 32'h5);
    expect_int("simul_readback_latency", lat, 2);
  endtask

  task automatic test_collision();
    int lat, nv, ne, nb;
    logic [31:0] d;
    run_strobe(1, 0, 1, 32'h8, 32'h0000_A5A5, 2, lat, nv, ne, nb, d);
    expect_int("coll_setup_err", ne, 0);
    lat = -1; nv = 0; ne = 0;
    mem_read4 = 1'b1; addr4 = 32'h8;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (rvalid4) begin
        nv++;
        if (lat < 0) lat = k - 1;
      end
      if (err4) ne++;
      if (k == 1) begin
        mem_read4 = 1'b0; mem_write4 = 1'b1; wdata4 = 32'hFFFF_FFFF;
      end else if (k == 3) begin
        mem_write4 = 1'b0;
      end
    end
    expect_int("coll_err", ne, 1);
    expect_int("coll_latency", lat, 4);
    expect_int("coll_rvalid_count", nv, 1);
    expect_word("coll_rdata", rdata4, 32'h0000_A5A5);
    run_strobe(1, 1, 0, 32'h8, 32'h0, 2, lat, nv, ne, nb, d);
    expect_word("coll_no_write", d, 32'h0000_A5A5);
    expect_int("coll_reread_latency", lat, 4);
  endtask

  task automatic test_reset_mid_read();
    int lat, nv, ne, nb;
    logic [31:0] d;
    mem_read = 1'b1; addr = 32'h10;
    step();
    expect_int("mid_busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    expect_int("mid_rvalid_in_reset", int'(rvalid), 0);
    expect_int("mid_busy_in_reset", int'(busy), 0);
    expect_word("mid_rdata_in_reset", rdata, 32'h0);
    mem_read = 1'b0;
    step();
    rst_n = 1'b1;
    nv = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (rvalid) nv++;
    end
    expect_int("mid_no_late_rvalid", nv, 0);
    run_strobe(0, 1, 0, 32'h10, 32'h0, 2, lat, nv, ne, nb, d);
    expect_word("mid_reread_rdata", d, 32'hDEADBEEF);
    expect_int("mid_reread_latency", lat, 2);
  endtask

  initial begin
    #1;
    test_reset();
    test_store_load();
    test_held_strobe();
    test_errors();
    test_top_word();
    test_simultaneous();
    test_collision();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
